// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: N-to-1 registered mux, fixed-select or round-robin; MUX_NTO1_XFER_CNT_EN adds xfer_cnt
module mux_nto1_rr #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  parameter int SELW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
`ifdef MUX_NTO1_XFER_CNT_EN
  ,output logic [15:0]       xfer_cnt
`endif
);
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  chan_q, chan_d, ptr_q, ptr_d, gidx;
  logic             valid_q, valid_d, found, can_load, grant;
  always_comb begin
    found = 1'b0;
    gidx = '0;
    if (mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[(int'(ptr_q) + i) % N]) begin
          found = 1'b1;
          gidx = SELW'((int'(ptr_q) + i) % N);
        end
      end
    end else begin
      gidx = sel;
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) found = 1'b1;
      end
    end
    can_load = !rst && (!valid_q || out_ready);
    grant = found && can_load;
    for (int i = 0; i < N; i++) in_ready[i] = grant && gidx == SELW'(i);
    data_d = rst ? '0 : grant ? in_data[int'(gidx)*WIDTH +: WIDTH] : data_q;
    chan_d = rst ? '0 : grant ? gidx : chan_q;
    valid_d = !rst && (grant || (valid_q && !out_ready));
    ptr_d = rst ? '0 : (grant && mode) ? SELW'((int'(gidx) + 1) % N) : ptr_q;
  end
  always_ff @(posedge clk) begin
    data_q <= data_d;
    chan_q <= chan_d;
    valid_q <= valid_d;
    ptr_q <= ptr_d;
  end
  assign out_data = data_q;
  assign out_chan = chan_q;
  assign out_valid = valid_q;
`ifdef MUX_NTO1_XFER_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = rst ? '0 : (valid_q && out_ready) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign xfer_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr: directed vector table plus reset and counter sequences for mux_nto1_rr
module tb_mux_nto1_rr;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data = {8'hD3, 8'hA5, 8'h5A, 8'h3C};
  logic [3:0]  in_valid, in_ready;
  logic        mode, out_valid, out_ready;
  logic [1:0]  sel, out_chan;
  logic [7:0]  out_data;
`ifdef MUX_NTO1_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif
  int vec_cnt = 0;
  int err_cnt = 0;
  always #5 clk = ~clk;
  mux_nto1_rr dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan)
`ifdef MUX_NTO1_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );
  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_chan;
    logic [7:0] exp_data;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  initial begin
    v[0]  = '{0, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'hA5};
    v[1]  = '{1, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'h3C};
    v[2]  = '{1, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'h5A};
    v[3]  = '{1, 0, 4'b1111, 1, 4'b0100, 1, 2, 8'hA5};
    v[4]  = '{1, 0, 4'b1111, 1, 4'b1000, 1, 3, 8'hD3};
    v[5]  = '{1, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'h3C};
    v[6]  = '{1, 0, 4'b1001, 1, 4'b1000, 1, 3, 8'hD3};
    v[7]  = '{1, 0, 4'b1001, 1, 4'b0001, 1, 0, 8'h3C};
    v[8]  = '{1, 0, 4'b1111, 0, 4'b0000, 1, 0, 8'h3C};
    v[9]  = '{1, 0, 4'b1111, 0, 4'b0000, 1, 0, 8'h3C};
    v[10] = '{1, 0, 4'b1111, 0, 4'b0000, 1, 0, 8'h3C};
    v[11] = '{1, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'h5A};
    v[12] = '{1, 0, 4'b0000, 1, 4'b0000, 0, 1, 8'h5A};
    v[13] = '{0, 1, 4'b1101, 1, 4'b0000, 0, 1, 8'h5A};
    v[14] = '{1, 0, 4'b1111, 1, 4'b0100, 1, 2, 8'hA5};
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset out_chan", 32'(out_chan), 0);
    for (int i = 0; i < 15; i++) begin
      mode = v[i].mode; sel = v[i].sel; in_valid = v[i].valid; out_ready = v[i].ordy;
      #1 chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v[i].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(v[i].exp_valid));
      chk($sformatf("v%0d out_chan", i), 32'(out_chan), 32'(v[i].exp_chan));
      chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(v[i].exp_data));
    end
    rst = 1'b1; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    #1 chk("rst in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("rst mid out_valid", 32'(out_valid), 0);
    chk("rst mid out_data", 32'(out_data), 0);
    chk("rst mid out_chan", 32'(out_chan), 0);
    rst = 1'b0; out_ready = 1'b1;
    #1 chk("post rst in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post rst out_chan", 32'(out_chan), 0);
    chk("post rst out_data", 32'(out_data), 32'h3C);
    chk("post rst out_valid", 32'(out_valid), 1);
`ifdef MUX_NTO1_XFER_CNT_EN
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("cnt reset", 32'(xfer_cnt), 0);
    @(posedge clk); #1;
    chk("cnt after load", 32'(xfer_cnt), 0);
    repeat (65535) @(posedge clk);
    #1 chk("cnt 65535", 32'(xfer_cnt), 32'hFFFF);
    @(posedge clk); #1;
    chk("cnt wrap", 32'(xfer_cnt), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
